sbox_scheduler: RTL and testbench

Time-shares a small number of `SubByte` S-box instances between the cipher round datapath, which needs a 16-byte SubBytes, and the key-expansion datapath, which needs a 4-byte SubWord. It accepts whole-word requests over valid/ready handshakes and arbitrates between the two requesters. It walks the bytes through the S-box lanes over several cycles and returns each result on its own response channel. It sits between the round controller / key scheduler and the S-box logic, replacing 20 parallel S-box copies.

---
 rtl/sbox_scheduler_pkg.sv | 22 ++
 rtl/sbox_scheduler_subbyte.sv | 45 ++++
 rtl/sbox_scheduler.sv | 122 ++++++++++++
 tb/tb_sbox_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_scheduler_pkg.sv
`default_nettype none
// sbox_scheduler_pkg: FSM state encoding, request byte counts and LANES legality helper.
// Revision 1.0
package sbox_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_ST  = 3'd1,
      RUN_KW  = 3'd2,
      DONE_ST = 3'd3,
      DONE_KW = 3'd4
   } state_t;

   localparam int ST_BYTES = 16;
   localparam int KW_BYTES = 4;

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_scheduler_subbyte.sv
`default_nettype none
// SubByte: combinational AES S-box, GF(2^8) inverse followed by the affine transform.
// Revision 1.0
module SubByte (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] w_inv;

   assign w_inv = gf_inv(in_i);
   assign out_o = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/sbox_scheduler.sv
`default_nettype none
// sbox_scheduler: shares LANES S-box instances between state SubBytes and key SubWord requests.
// Revision 1.0
module sbox_scheduler
   import sbox_scheduler_pkg::*;
#(
   parameter int LANES        = 1,
   parameter bit KEY_PRIORITY = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   input  logic         st_rsp_ready,
   output logic [127:0] st_rsp_data,
   input  logic         kw_req_valid,
   output logic         kw_req_ready,
   input  logic [31:0]  kw_req_data,
   output logic         kw_rsp_valid,
   input  logic         kw_rsp_ready,
   output logic [31:0]  kw_rsp_data
);

   localparam logic [4:0] STEP = 5'(LANES);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sbox_scheduler: LANES must be 1, 2 or 4");
   end

   state_t       state_q, state_d;
   logic [4:0]   idx_q, idx_d;
   logic [127:0] src_q, src_d;
   logic [127:0] res_q, res_d;
   logic         last_kw_q, last_kw_d;

   logic         w_idle;
   logic         w_kw_grant;
   logic         w_st_grant;
   logic [3:0]   w_pos    [LANES];
   logic [7:0]   w_sb_in  [LANES];
   logic [7:0]   w_sb_out [LANES];

   // Round-robin: kw only wins a tie when st was not the loser last time.
   assign w_idle     = (state_q == IDLE);
   assign w_kw_grant = w_idle && kw_req_valid && (KEY_PRIORITY || !st_req_valid || !last_kw_q);
   assign w_st_grant = w_idle && st_req_valid && !w_kw_grant;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_pos[gi]   = idx_q[3:0] + 4'(gi);
      assign w_sb_in[gi] = src_q[{w_pos[gi], 3'b000} +: 8];
      SubByte u_subbyte (
         .in_i  (w_sb_in[gi]),
         .out_o (w_sb_out[gi])
      );
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      src_d     = src_q;
      res_d     = res_q;
      last_kw_d = last_kw_q;
      unique case (state_q)
         IDLE: begin
            if (w_kw_grant) begin
               src_d     = {96'b0, kw_req_data};
               res_d     = '0;
               idx_d     = '0;
               last_kw_d = 1'b1;
               state_d   = RUN_KW;
            end else if (w_st_grant) begin
               src_d     = st_req_data;
               res_d     = '0;
               idx_d     = '0;
               last_kw_d = 1'b0;
               state_d   = RUN_ST;
            end
         end
         RUN_ST, RUN_KW: begin
            for (int l = 0; l < LANES; l++) begin
               res_d[{w_pos[l], 3'b000} +: 8] = w_sb_out[l];
            end
            idx_d = idx_q + STEP;
            if (state_q == RUN_ST) begin
               if (idx_d == 5'(ST_BYTES)) state_d = DONE_ST;
            end else if (idx_d == 5'(KW_BYTES)) begin
               state_d = DONE_KW;
            end
         end
         DONE_ST: if (st_rsp_ready) state_d = IDLE;
         DONE_KW: if (kw_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         src_q     <= '0;
         res_q     <= '0;
         last_kw_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         src_q     <= src_d;
         res_q     <= res_d;
         last_kw_q <= last_kw_d;
      end
   end

   assign st_req_ready = w_st_grant;
   assign kw_req_ready = w_kw_grant;
   assign st_rsp_valid = (state_q == DONE_ST);
   assign kw_rsp_valid = (state_q == DONE_KW);
   assign st_rsp_data  = res_q;
   assign kw_rsp_data  = res_q[31:0];

endmodule
`default_nettype wire

// File: tb/tb_sbox_scheduler.sv
`default_nettype none
// tb_sbox_scheduler: directed and randomized checks of two scheduler instances against an S-box model.
// Revision 1.0
module tb_sbox_scheduler;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Instance 0: LANES=1, key priority.  Instance 1: LANES=4, round-robin.
   logic [1:0]   st_req_valid, st_rsp_ready, kw_req_valid, kw_rsp_ready;
   wire  [1:0]   st_req_ready, st_rsp_valid, kw_req_ready, kw_rsp_valid;
   logic [127:0] st_req_data [2];
   logic [31:0]  kw_req_data [2];
   wire  [127:0] st_rsp_data [2];
   wire  [31:0]  kw_rsp_data [2];

   sbox_scheduler #(.LANES(1), .KEY_PRIORITY(1'b1)) u_dut_l1 (
      .clk(clk), .reset_n(reset_n),
      .st_req_valid(st_req_valid[0]), .st_req_ready(st_req_ready[0]), .st_req_data(st_req_data[0]),
      .st_rsp_valid(st_rsp_valid[0]), .st_rsp_ready(st_rsp_ready[0]), .st_rsp_data(st_rsp_data[0]),
      .kw_req_valid(kw_req_valid[0]), .kw_req_ready(kw_req_ready[0]), .kw_req_data(kw_req_data[0]),
      .kw_rsp_valid(kw_rsp_valid[0]), .kw_rsp_ready(kw_rsp_ready[0]), .kw_rsp_data(kw_rsp_data[0])
   );

   sbox_scheduler #(.LANES(4), .KEY_PRIORITY(1'b0)) u_dut_l4 (
      .clk(clk), .reset_n(reset_n),
      .st_req_valid(st_req_valid[1]), .st_req_ready(st_req_ready[1]), .st_req_data(st_req_data[1]),
      .st_rsp_valid(st_rsp_valid[1]), .st_rsp_ready(st_rsp_ready[1]), .st_rsp_data(st_rsp_data[1]),
      .kw_req_valid(kw_req_valid[1]), .kw_req_ready(kw_req_ready[1]), .kw_req_data(kw_req_data[1]),
      .kw_rsp_valid(kw_rsp_valid[1]), .kw_rsp_ready(kw_rsp_ready[1]), .kw_rsp_data(kw_rsp_data[1])
   );

   logic [7:0] sbox_tab [256];
   bit         last_kw  [2];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference S-box: polynomial product reduced mod x^8+x^4+x^3+x+1, inverse by search.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      inv = '0;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return s;
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] v, input int nbytes);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < nbytes; k++) r[8*k +: 8] = sbox_tab[v[8*k +: 8]];
      return r;
   endfunction

   function automatic int lanes_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic bit model_kw_wins(input int d, input bit stv, input bit kwv);
      return kwv && ((d == 0) || !stv || !last_kw[d]);
   endfunction

   function automatic bit rdy(input int d, input bit kw);
      return kw ? kw_req_ready[d] : st_req_ready[d];
   endfunction

   function automatic bit vld(input int d, input bit kw);
      return kw ? kw_rsp_valid[d] : st_rsp_valid[d];
   endfunction

   function automatic logic [127:0] rsp(input int d, input bit kw);
      return kw ? {96'b0, kw_rsp_data[d]} : st_rsp_data[d];
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_req(input int d, input bit kw, input bit v, input logic [127:0] data);
      if (kw) begin
         kw_req_valid[d] = v;
         kw_req_data[d]  = data[31:0];
      end else begin
         st_req_valid[d] = v;
         st_req_data[d]  = data;
      end
   endtask

   // Leaves the caller #1 after a negedge with the request granted; accept happens at the next posedge.
   task automatic start_op(input int d, input bit kw, input logic [127:0] data);
      int n;
      n = 0;
      @(negedge clk);
      set_req(d, kw, 1'b1, data);
      #1;
      while (!rdy(d, kw) && n < 40) begin
         @(negedge clk); #1; n++;
      end
      check("grant", 128'(rdy(d, kw)), 128'(1));
   endtask

   task automatic finish_op(input int d, input bit kw, input logic [127:0] data, input int bp,
                            input bit raise_other, input logic [127:0] other_data,
                            output logic [127:0] got);
      logic [127:0] exp;
      int lat, nb;
      bit leak, moved;
      lat   = 1;
      leak  = 1'b0;
      moved = 1'b0;
      nb    = kw ? 4 : 16;
      exp   = ref_sub(kw ? {96'b0, data[31:0]} : data, nb);
      last_kw[d] = kw;
      @(negedge clk);
      set_req(d, kw, 1'b0, '0);
      if (raise_other) set_req(d, !kw, 1'b1, other_data);
      #1;
      while (!vld(d, kw) && lat < 40) begin
         leak |= rdy(d, !kw);
         @(negedge clk); #1; lat++;
      end
      check("latency", 128'(lat), 128'(nb / lanes_of(d) + 1));
      got = rsp(d, kw);
      check(kw ? "kw_data" : "st_data", got, exp);
      for (int i = 0; i < bp; i++) begin
         leak |= rdy(d, !kw);
         @(negedge clk); #1;
         if (rsp(d, kw) !== got || !vld(d, kw)) moved = 1'b1;
      end
      if (bp > 0) check("rsp_stable", 128'(moved), 128'(0));
      leak |= rdy(d, !kw);
      if (kw) kw_rsp_ready[d] = 1'b1; else st_rsp_ready[d] = 1'b1;
      @(negedge clk);
      kw_rsp_ready[d] = 1'b0;
      st_rsp_ready[d] = 1'b0;
      #1;
      check("rsp_clear", 128'(vld(d, kw)), 128'(0));
      check("no_grant_busy", 128'(leak), 128'(0));
   endtask

   task automatic do_op(input int d, input bit kw, input logic [127:0] data, input int bp,
                        output logic [127:0] got);
      start_op(d, kw, data);
      finish_op(d, kw, data, bp, 1'b0, '0, got);
   endtask

   task automatic tie(input int d, input logic [127:0] sd, input logic [31:0] kd);
      bit kw_first;
      logic [127:0] got;
      kw_first = model_kw_wins(d, 1'b1, 1'b1);
      @(negedge clk);
      set_req(d, 1'b0, 1'b1, sd);
      set_req(d, 1'b1, 1'b1, {96'b0, kd});
      #1;
      check("tie_kw_ready", 128'(kw_req_ready[d]), 128'(kw_first));
      check("tie_st_ready", 128'(st_req_ready[d]), 128'(!kw_first));
      finish_op(d, kw_first, kw_first ? {96'b0, kd} : sd, 0, 1'b0, '0, got);
      check("loser_ready", 128'(rdy(d, !kw_first)), 128'(1));
      finish_op(d, !kw_first, kw_first ? sd : {96'b0, kd}, 0, 1'b0, '0, got);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] got;
      logic [127:0] kwd;
      bit seen;
      reset_n      = 1'b0;
      st_req_valid = '0;
      kw_req_valid = '0;
      st_rsp_ready = '0;
      kw_rsp_ready = '0;
      for (int d = 0; d < 2; d++) begin
         st_req_data[d] = '0;
         kw_req_data[d] = '0;
         last_kw[d]     = 1'b1;
      end
      for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_flags", 128'({st_req_ready[d], kw_req_ready[d], st_rsp_valid[d], kw_rsp_valid[d]}), 128'(0));
         check("rst_data", st_rsp_data[d] | {96'b0, kw_rsp_data[d]}, '0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("idle_no_ready", 128'({st_req_ready, kw_req_ready}), 128'(0));

      do_op(0, 1'b1, 128'h0, 0, got);
      check("kw_zero", got, 128'h63636363);
      do_op(0, 1'b1, 128'hFF530100, 0, got);
      check("kw_bytes", got, 128'h16ED7C63);
      do_op(0, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, got);
      check("fips_state_l1", got, 128'hd42711aee0bf98f1b8b45de51e415230);
      do_op(0, 1'b1, 128'hcf4f3c09, 0, got);
      check("fips_kw_l1", got, 128'h8a84eb01);
      do_op(1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, got);
      check("fips_state_l4", got, 128'hd42711aee0bf98f1b8b45de51e415230);
      do_op(1, 1'b1, 128'hcf4f3c09, 0, got);
      check("fips_kw_l4", got, 128'h8a84eb01);

      tie(0, rnd128(), $urandom);
      tie(1, rnd128(), $urandom);
      tie(1, rnd128(), $urandom);

      // Back-pressure with a key request arriving while the state result is held.
      kwd = {96'b0, $urandom};
      got = rnd128();
      start_op(0, 1'b0, got);
      finish_op(0, 1'b0, got, 10, 1'b1, kwd, got);
      check("kw_after_bp", 128'(kw_req_ready[0]), 128'(1));
      finish_op(0, 1'b1, kwd, 0, 1'b0, '0, got);

      for (int it = 0; it < 30; it++) begin
         int d, mode, bp;
         d    = int'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 2));
         bp   = int'($urandom_range(0, 3));
         if (mode == 2) tie(d, rnd128(), $urandom);
         else do_op(d, mode == 1, rnd128(), bp, got);
      end

      // Reset in the middle of a state operation.
      start_op(0, 1'b0, rnd128());
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, '0);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_valid", 128'({st_rsp_valid[0], kw_rsp_valid[0]}), 128'(0));
      check("midrst_data", st_rsp_data[0], '0);
      repeat (2) @(negedge clk);
      reset_n    = 1'b1;
      last_kw[0] = 1'b1;
      last_kw[1] = 1'b1;
      seen       = 1'b0;
      repeat (20) begin
         @(negedge clk); #1;
         seen |= st_rsp_valid[0];
      end
      check("no_rsp_after_rst", 128'(seen), 128'(0));
      do_op(0, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, got);
      check("post_rst_state", got, 128'hd42711aee0bf98f1b8b45de51e415230);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
